muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_unit.sv | 131 +++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 op codes, FSM state type and the iteration count.
package muldiv_unit_pkg;

    localparam int ITER = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on
// operand magnitudes, sign fix-up in DONE, fixed 33-edge latency to done.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t            state_reg, state_next;
    logic [4:0]        cnt_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   a_reg, mag_reg, result_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic              neg_reg, a_neg_reg, b_zero_reg, done_reg;

    // Operand magnitudes for latching at the start edge
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = op_a_signed(funct3) & a[XLEN-1];
        b_neg = op_b_signed(funct3) & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration step: shift-add multiply keeps {hi, lo} of the product,
    // restoring divide keeps {remainder, quotient}.
    logic [XLEN:0]     mul_sum, rem_shift;
    logic [XLEN-1:0]   rem_sub;
    logic              rem_ge;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mag_reg} : '0);
        rem_shift = acc_reg[2*XLEN-1:XLEN-1];
        rem_ge    = rem_shift >= {1'b0, mag_reg};
        rem_sub   = rem_shift[XLEN-1:0] - mag_reg;
        acc_step  = '0;
        if (!op_reg[2])
            acc_step = {mul_sum, acc_reg[XLEN-1:1]};
        else if (rem_ge)
            acc_step = {rem_sub, acc_reg[XLEN-2:0], 1'b1};
        else
            acc_step = {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed, rem_signed, result_final;

    always_comb begin
        prod_signed  = neg_reg ? -acc_reg : acc_reg;
        quo_signed   = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem_signed   = a_neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
        result_final = '0;
        if (!op_reg[2])
            result_final = (op_reg[1:0] == 2'b00) ? prod_signed[XLEN-1:0]
                                                  : prod_signed[2*XLEN-1:XLEN];
        else if (b_zero_reg)
            result_final = op_reg[1] ? a_reg : '1;
        else
            result_final = op_reg[1] ? rem_signed : quo_signed;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (cnt_reg == LAST_ITER) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            mag_reg    <= '0;
            acc_reg    <= '0;
            neg_reg    <= 1'b0;
            a_neg_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: if (start) begin
                    op_reg     <= funct3;
                    a_reg      <= a;
                    cnt_reg    <= '0;
                    neg_reg    <= a_neg ^ b_neg;
                    a_neg_reg  <= a_neg;
                    b_zero_reg <= (b == '0);
                    acc_reg    <= funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                    mag_reg    <= funct3[2] ? b_mag : a_mag;
                end
                ST_CALC: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 5'd1;
                end
                ST_DONE: begin
                    result_reg <= result_final;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, random ops
// against a plain-arithmetic reference, input-ignore, back-to-back and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p;
        longint unsigned up;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; return x / y; end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin if (y == 0) return x; return x % y; end
        endcase
    endfunction

    // Launch one op from IDLE, scramble inputs after acceptance, wait for done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        funct3 = f; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
        busy_ok = busy;
        lat = -1;
        res = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; res = result;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] xa [12]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] xb [12]  = '{32'hFFFFFFFA, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp_v [12] = '{32'hFFFFFFD6, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                    32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        logic [31:0] res;
        int lat;
        bit bok;
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], xa[i], xb[i], res, lat, bok);
            checks++;
            if (res !== exp_v[i]) begin
                failures++;
                $display("FAIL directed_result[%0d] f=%0d a=%h b=%h: got %h, required %h", i, ops[i], xa[i], xb[i], res, exp_v[i]);
            end
            checks++;
            if (lat != 33 || !bok) begin
                failures++;
                $display("FAIL directed_latency[%0d]: latency=%0d busy_ok=%0d, required 33 1", i, lat, bok);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] special [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h1};
        logic [31:0] x, y, res, expv;
        logic [2:0]  f;
        int lat;
        bit bok;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            x = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            expv = ref_op(f, x, y);
            run_op(f, x, y, res, lat, bok);
            checks++;
            if (res !== expv || lat != 33 || !bok) begin
                failures++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: got %h lat=%0d busy_ok=%0d, required %h lat=33", i, f, x, y, res, lat, bok, expv);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || result !== expv) begin
                failures++;
                $display("FAIL random_hold[%0d]: done=%b result=%h, required 0 %h", i, done, result, expv);
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int lat = -1;
        logic [31:0] res = 'x;
        @(negedge clk);
        funct3 = 3'd5; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 9) begin start = 1'b1; a = $urandom; b = $urandom; funct3 = 3'($urandom); end
            if (k == 10) start = 1'b0;
            if (done) begin lat = k; res = result; break; end
        end
        checks++;
        if (res !== 32'd142 || lat != 33) begin
            failures++;
            $display("FAIL ignore_inputs: got %h lat=%0d, required 0000008e lat=33", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        logic [31:0] res = 'x;
        @(negedge clk);
        funct3 = 3'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin lat = k; res = result; break; end
        end
        checks++;
        if (res !== 32'hFFFFFFFE || lat != 33) begin
            failures++;
            $display("FAIL b2b_first: got %h lat=%0d, required fffffffe lat=33", res, lat);
        end
        funct3 = 3'd6; a = 32'hFFFFFFF9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        lat = -1; res = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin lat = k; res = result; break; end
        end
        checks++;
        if (res !== ref_op(3'd6, 32'hFFFFFFF9, 32'd2) || lat != 33) begin
            failures++;
            $display("FAIL b2b_second: got %h lat=%0d, required ffffffff lat=33", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        logic [31:0] res;
        int lat;
        bit bok;
        @(negedge clk);
        funct3 = 3'd0; a = 32'd12345; b = 32'd678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        repeat (40) begin
            @(negedge clk);
            if (done) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_no_done: done pulses=%0d, required 0", stray);
        end
        run_op(3'd4, 32'hFFFFFF9C, 32'd7, res, lat, bok);
        checks++;
        if (res !== ref_op(3'd4, 32'hFFFFFF9C, 32'd7) || lat != 33 || !bok) begin
            failures++;
            $display("FAIL after_reset: got %h lat=%0d, required %h lat=33", res, lat, ref_op(3'd4, 32'hFFFFFF9C, 32'd7));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
